// File: rtl/mem_clear_seq.sv
// Memory clear sequencer: once the upstream stage reports ready, sweep every
// word of the local memory with FILL, then forward single-word user requests
// with a req/ack handshake. All outputs are registered.
module mem_clear_seq #(
    parameter int unsigned          ADDR_W = 4,
    parameter int unsigned          DATA_W = 8,
    parameter logic [DATA_W-1:0]    FILL   = '0
) (
    input  logic                pulse,
    input  logic                rst,
    input  logic                ready,
    input  logic                usr_req,
    input  logic                usr_we,
    input  logic [ADDR_W-1:0]   usr_addr,
    input  logic [DATA_W-1:0]   usr_wdata,
    output logic                usr_ack,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                init_done
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     cnt_inc;
    logic                ack_q, ack_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // cnt_q holds the address currently driven; the extra MSB flags the end
    // of the sweep so the terminal test never aliases back to address 0.
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                addr_d  = '0;
                wdata_d = '0;
                if (ready) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    wdata_d = FILL;
                end
            end

            StClear: begin
                if (!ready) begin
                    state_d = StIdle;
                    addr_d  = '0;
                    wdata_d = '0;
                end else if (cnt_inc[ADDR_W]) begin
                    // Last address has been driven for one cycle.
                    state_d = StRun;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = cnt_inc[ADDR_W-1:0];
                    wdata_d = FILL;
                end
            end

            StRun: begin
                if (!ready) begin
                    state_d = StIdle;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    done_d = 1'b1;
                    // Gating on the ack keeps a held request from being taken twice.
                    if (usr_req && !ack_q) begin
                        ack_d   = 1'b1;
                        we_d    = usr_we;
                        addr_d  = usr_addr;
                        wdata_d = usr_wdata;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pulse) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign usr_ack   = ack_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_mem_clear_seq.sv
// Directed bench for mem_clear_seq with ADDR_W=4, DATA_W=8, FILL=8'hA5.
module tb_mem_clear_seq;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam logic [7:0]  FILLV  = 8'hA5;

    logic              pulse = 1'b0;
    logic              rst = 1'b1;
    logic              ready = 1'b0;
    logic              usr_req = 1'b0;
    logic              usr_we = 1'b0;
    logic [ADDR_W-1:0] usr_addr = '0;
    logic [DATA_W-1:0] usr_wdata = '0;
    logic              usr_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              init_done;

    int total = 0;
    int bad   = 0;
    int acks;

    mem_clear_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .FILL   (FILLV)
    ) dut (
        .pulse     (pulse),
        .rst       (rst),
        .ready     (ready),
        .usr_req   (usr_req),
        .usr_we    (usr_we),
        .usr_addr  (usr_addr),
        .usr_wdata (usr_wdata),
        .usr_ack   (usr_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 pulse = ~pulse;

    task automatic tick();
        @(posedge pulse);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ack, input logic we,
                           input logic [3:0] addr, input logic [7:0] wd,
                           input logic bsy, input logic dn);
        chk({tag, ".ack"},   32'(usr_ack),   32'(ack));
        chk({tag, ".we"},    32'(mem_we),    32'(we));
        chk({tag, ".addr"},  32'(mem_addr),  32'(addr));
        chk({tag, ".wdata"}, 32'(mem_wdata), 32'(wd));
        chk({tag, ".busy"},  32'(busy),      32'(bsy));
        chk({tag, ".done"},  32'(init_done), 32'(dn));
    endtask

    // Full 16-word sweep from IDLE with ready already high, then the RUN entry cycle.
    task automatic full_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_all(tag, 1'b0, 1'b1, 4'(i), FILLV, 1'b1, 1'b0);
        end
        tick();
        chk_all({tag, "_run"}, 1'b0, 1'b0, 4'd15, FILLV, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset, then idle with ready low.
        tick();
        tick();
        chk_all("reset", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        end

        // Early write request held across the sweep.
        usr_req   = 1'b1;
        usr_we    = 1'b1;
        usr_addr  = 4'd3;
        usr_wdata = 8'h5C;
        ready     = 1'b1;
        full_sweep("sweep1");
        tick();
        chk_all("early_ack", 1'b1, 1'b1, 4'd3, 8'h5C, 1'b0, 1'b1);
        usr_req = 1'b0;
        tick();
        chk_all("early_after", 1'b0, 1'b0, 4'd3, 8'h5C, 1'b0, 1'b1);

        // Held request for 6 cycles: acks on alternating cycles.
        usr_req   = 1'b1;
        usr_we    = 1'b1;
        usr_addr  = 4'd5;
        usr_wdata = 8'h11;
        acks      = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b2b_ack", 32'(usr_ack), 32'((i % 2) == 0));
            if (usr_ack) acks++;
        end
        chk("b2b_count", 32'(acks), 32'd3);
        usr_req = 1'b0;

        // Read request.
        usr_req  = 1'b1;
        usr_we   = 1'b0;
        usr_addr = 4'd7;
        tick();
        chk_all("read_ack", 1'b1, 1'b0, 4'd7, 8'h11, 1'b0, 1'b1);
        usr_req = 1'b0;
        tick();
        chk_all("read_after", 1'b0, 1'b0, 4'd7, 8'h11, 1'b0, 1'b1);

        // Synchronous reset in RUN with a pending request.
        usr_req  = 1'b1;
        usr_we   = 1'b1;
        usr_addr = 4'd2;
        rst      = 1'b1;
        tick();
        chk_all("rst_run", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        rst     = 1'b0;
        usr_req = 1'b0;
        full_sweep("sweep2");

        // ready falls in RUN.
        ready = 1'b0;
        tick();
        chk_all("run_drop", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);

        // Abort mid-sweep at address 9.
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("part", 1'b0, 1'b1, 4'(i), FILLV, 1'b1, 1'b0);
        end
        ready = 1'b0;
        tick();
        chk_all("abort", 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        ready = 1'b1;
        full_sweep("sweep3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_clear_seq.md
Name: mem_clear_seq

Overview:
- Consumer stage directly downstream of the power-up pulse counter.
- Waits for that stage's sticky `ready` level, then sweeps the whole local memory, writing a fill value to every address.
- Raises `init_done` when the sweep completes, then forwards single-word user read/write requests to the memory port using a req/ack handshake.
- Guarantees that no user access reaches memory before it has been cleared.

Parameters:
- ADDR_W, 4, memory address width; the sweep covers 2^ADDR_W words.
- DATA_W, 8, memory data width.
- FILL, 0, value written to every word during the sweep (DATA_W bits).

Ports:
- pulse  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ready  input  1  level from the upstream pulse-counter stage; high = memory may be prepared.
- usr_req  input  1  user request; held high until usr_ack is seen.
- usr_we  input  1  1 = write, 0 = read; sampled with usr_req.
- usr_addr  input  ADDR_W  user address.
- usr_wdata  input  DATA_W  user write data.
- usr_ack  output  1  one-cycle acknowledge of an accepted request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- busy  output  1  high while in CLEAR.
- init_done  output  1  high while in RUN.

Behaviour:
- Reset and clocking:
  - Clock is `pulse`; reset is `rst`, synchronous and active-high.
  - All outputs are registered.
  - When rst=1 at an edge: state=IDLE, and usr_ack, mem_we, mem_addr, mem_wdata, busy, init_done all become 0.
  - rst overrides every other input in the same cycle.
- States:
  - IDLE: outputs 0. ready=1 sampled at an edge -> CLEAR with sweep counter=0.
  - CLEAR:
    - The cycle after entry: busy=1, mem_we=1, mem_addr=0, mem_wdata=FILL.
    - Each following cycle mem_addr increments by 1.
    - The sweep lasts exactly 2^ADDR_W cycles with mem_we=1, addresses 0..2^ADDR_W-1, in order, no gaps or repeats.
    - After address 2^ADDR_W-1 has been driven for one cycle -> RUN.
    - The counter is ADDR_W+1 bits; terminal detection must not wrap to address 0.
  - RUN:
    - init_done=1, busy=0, mem_we=0 when idle.
    - A request is accepted at an edge where usr_req=1 and usr_ack=0.
    - The next cycle: usr_ack=1, mem_we=usr_we, mem_addr=usr_addr, mem_wdata=usr_wdata (captured values).
    - Every other cycle: usr_ack=0 and mem_we=0.
    - mem_addr and mem_wdata hold their last values.
    - Because of the usr_ack=0 condition, a request held through its ack cycle is not accepted twice. Maximum throughput is one request per 2 cycles.
- Requests before RUN: usr_req in IDLE or CLEAR is ignored, usr_ack stays 0, and the request stays pending. The first acceptance is possible at the first edge in RUN.
- ready falls:
  - In CLEAR or RUN, the next state is IDLE and all outputs return to 0 (init_done=0, any pending ack dropped).
  - A later re-rise of ready restarts the full sweep from address 0.
- ready=1 while already in CLEAR or RUN: no effect; there is no retrigger.
- Reset mid-sweep: immediate return to IDLE. After rst releases, if ready=1, the sweep restarts from address 0.
- Read data path is outside this block; usr_ack on a read only marks the cycle mem_addr is valid.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ready=0 for 10 cycles -> all outputs 0, no mem_we.
- Sweep (ADDR_W=4, FILL=8'hA5): ready rises -> mem_we=1 for exactly 16 consecutive cycles, mem_addr 0..15 in order, mem_wdata=A5, busy=1 throughout; init_done=1 the cycle after addr 15, busy=0.
- Early request: usr_req=1, usr_we=1, addr=3, data=8'h5C held from before ready rises -> no ack during sweep; first RUN cycle accepts; next cycle usr_ack=1, mem_we=1, mem_addr=3, mem_wdata=5C; exactly one ack.
- Back-to-back: usr_req held high for 6 cycles in RUN -> exactly 3 ack pulses on alternating cycles. A read (usr_we=0, addr=7) -> mem_we=0, mem_addr=7 with ack.
- Abort: ready dropped at sweep address 9 -> next cycle IDLE, mem_we=0, busy=0; ready re-raised -> sweep restarts at address 0 and runs a full 16 cycles.
- Sync reset in RUN with usr_req=1: rst=1 one cycle -> all outputs 0 next cycle, no ack. Release with ready=1 -> new full sweep.
